// File: rtl/rot_pkg.sv
// rtl/rot_pkg.sv - shared types and constants for the rotate arbiter slice
package rot_pkg;

  localparam int ROT_W = 4;

  typedef logic [1:0] rot_amt_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/rot4_core.sv
// rtl/rot4_core.sv - combinational 4-bit rotator, right by amt or left by amt
module rot4_core
  import rot_pkg::*;
(
  input  logic [ROT_W-1:0] i_data,
  input  rot_amt_t         i_amt,
  input  logic             i_dir,
  output logic [ROT_W-1:0] o_data
);

  rot_amt_t w_shift;

  // A left rotate by s is a right rotate by (4-s) mod 4; 2-bit wrap gives that for free.
  assign w_shift = (i_dir == DIR_LEFT) ? (2'd0 - i_amt) : i_amt;

  always_comb begin
    o_data = '0;
    for (int k = 0; k < ROT_W; k++) begin
      o_data[k] = i_data[2'(k) + w_shift];
    end
  end

endmodule

// File: rtl/rot_arbiter.sv
// rtl/rot_arbiter.sv - round-robin arbiter sharing one rotator, single-entry output register
module rot_arbiter
  import rot_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*ROT_W-1:0] req_data,
  input  logic [NREQ*2-1:0]     req_amt,
  input  logic [NREQ-1:0]       req_dir,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ROT_W-1:0]      out_data,
  output logic [ID_W-1:0]       out_id
);

  out_state_t       r_state;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ROT_W-1:0] r_out_data;
  logic [ID_W-1:0]  r_out_id;

  logic [ID_W:0]    w_scan;
  logic [ID_W-1:0]  w_scan_id;
  logic [ID_W-1:0]  w_win;
  logic             w_found;
  logic [ROT_W-1:0] w_sel_data;
  rot_amt_t         w_sel_amt;
  logic             w_sel_dir;
  logic [ROT_W-1:0] w_rot;
  logic             w_accept;
  logic             w_xfer;

  always_comb begin
    w_scan     = '0;
    w_scan_id  = '0;
    w_win      = '0;
    w_found    = 1'b0;
    w_sel_data = '0;
    w_sel_amt  = '0;
    w_sel_dir  = DIR_RIGHT;
    // Wrap at NREQ rather than 2**ID_W so unused ID codes are never produced.
    for (int i = 0; i < NREQ; i++) begin
      w_scan = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
      if (w_scan >= (ID_W+1)'(NREQ)) begin
        w_scan = w_scan - (ID_W+1)'(NREQ);
      end
      w_scan_id = w_scan[ID_W-1:0];
      if (!w_found && req_valid[w_scan_id]) begin
        w_found = 1'b1;
        w_win   = w_scan_id;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (ID_W'(k) == w_win) begin
        w_sel_data = req_data[k*ROT_W +: ROT_W];
        w_sel_amt  = req_amt[k*2 +: 2];
        w_sel_dir  = req_dir[k];
      end
    end
  end

  rot4_core u_rot4_core (
    .i_data (w_sel_data),
    .i_amt  (w_sel_amt),
    .i_dir  (w_sel_dir),
    .o_data (w_rot)
  );

  assign w_accept  = (r_state == ST_EMPTY) || out_ready;
  assign w_xfer    = w_found && w_accept && rst_n;
  assign req_ready = w_xfer ? (NREQ'(1) << w_win) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_rr_ptr   <= '0;
      r_out_data <= '0;
      r_out_id   <= '0;
    end else if (w_xfer) begin
      r_state    <= ST_FULL;
      r_out_data <= w_rot;
      r_out_id   <= w_win;
      r_rr_ptr   <= (w_win == ID_W'(NREQ-1)) ? '0 : w_win + 1'b1;
    end else if (r_state == ST_FULL && out_ready) begin
      r_state <= ST_EMPTY;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;

endmodule

// File: doc/rot_arbiter.md
Name: rot_arbiter

Overview:
- Shares one 4-bit rotate datapath among NREQ requesters using round-robin arbitration.
- Accepts at most one request per cycle.
- Rotates the accepted word by 0..3 positions, left or right.
- Delivers the result through a single-entry registered output with valid/ready backpressure, tagged with the requester ID.
- Sits between the client blocks and downstream consumers of rotated nibbles.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; equals clog2(NREQ), minimum 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_data  in  NREQ*4  requester k word at bits [4k+3:4k].
- req_amt  in  NREQ*2  requester k rotate amount at bits [2k+1:2k].
- req_dir  in  NREQ  0 = rotate right, 1 = rotate left.
- out_valid  out  1  result register holds valid data.
- out_ready  in  1  downstream accepts the result.
- out_data  out  4  rotated word.
- out_id  out  ID_W  index of the requester that produced out_data.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_id=0, rr_ptr=0, output state EMPTY. req_ready is combinational and is 0 while out_valid=0 with no req_valid, or while in reset.
- Rotate function, right by s: o[k] = i[(k+s) mod 4]. Left by s equals right by (4-s) mod 4. Amount 0 passes data through for either direction.
- Output register states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Accept condition: accept = (state==EMPTY) or (out_valid and out_ready).
- Arbitration:
  - Scan requesters starting at rr_ptr, in increasing index order with wrap-around.
  - The first k with req_valid[k] wins. req_ready[k] = win[k] and accept.
  - req_ready is combinational from req_valid, rr_ptr, state and out_ready.
- Transfer: req_valid[k] and req_ready[k] in the same cycle.
  - Next edge: out_data = rotate(req_data[k], req_amt[k], req_dir[k]), out_id = k, state = FULL.
  - rr_ptr = (k+1) mod NREQ.
- Drain without a new transfer: out_valid and out_ready with no req transfer -> state EMPTY next cycle. out_data and out_id hold their last values.
- Simultaneous drain and new transfer: the register reloads and out_valid stays 1. Full throughput is 1 result per cycle.
- Stall: FULL with out_ready=0 -> all req_ready=0. out_data, out_id and out_valid are held stable.
- Latency: 1 cycle from transfer to out_valid.
- rr_ptr changes only on a transfer.
- Fairness: with all requesters valid, each is granted exactly once per NREQ consecutive transfers.
- Requester protocol: requesters hold req_data, req_amt and req_dir stable while req_valid is high and not yet accepted. The block does not check this.
- Reset mid-operation: a pending result is discarded, out_valid drops immediately, and the pointer returns to 0.
- NREQ not a power of 2: rr_ptr wraps at NREQ-1 -> 0. Unused ID codes never appear.

Decomposition:
- Shared package rot_pkg:
  - ROT_W=4.
  - typedef rot_amt_t (2 bits).
  - constants DIR_RIGHT=0, DIR_LEFT=1.
- One sub-module, rot4_core: combinational 4-bit rotator taking data, amount and direction. It is instantiated once after the arbitration mux, so the rotate logic is shared.
- Arbiter, pointer and output register stay in rot_arbiter.

Test Plan:
- Reset then a single request. req0: data 4'b1011, amt 2, dir 0, out_ready=1 -> next cycle out_valid=1, out_data=4'b1110, out_id=0. Then out_valid=0.
- Direction check on requester 2, data 4'b0001:
  - amt 1, dir 0 -> out_data=4'b1000, out_id=2.
  - amt 1, dir 1 -> 4'b0010.
  - amt 0 -> 4'b0001.
- Round robin: all 4 requesters valid continuously, out_ready=1 -> out_id sequence 0,1,2,3,0,1. One req_ready per cycle and out_valid high every cycle after the first.
- Backpressure: FULL with out_ready=0 for 5 cycles while req1 and req3 are valid -> req_ready=0, out_data and out_id stable. Raise out_ready -> drain and new accept in the same cycle, and the next grant follows rr_ptr order.
- Pointer skip: rr_ptr=1 and only req0 valid -> req0 is granted (wrap), and rr_ptr becomes 1.
- Async reset while FULL, mid-cycle -> out_valid=0 immediately without a clock edge. After release, the first grant goes to the lowest valid index starting from 0.
